// File: rtl/bxu_code_loader_if.sv
// ----------------------------------------------------------------------------
// bxu_code_loader_if
//
// Bundles the three buses the code loader sits between:
//   - UART receive handshake : rx_data, rx_ready, rx_done
//   - BXU fetch side         : bxu_code_addr, bxu_code, bxu_rst_n
//   - shared code RAM port   : mem_addr, mem_wdata, mem_we, mem_rdata
//
// Receive handshake: rx_ready is a level meaning "rx_data holds a byte".
// The loader takes the byte on a clock edge where rx_ready=1, answers with
// a single-cycle rx_done in the following cycle, and will not take another
// byte until it has observed rx_ready=0. The sender keeps rx_data stable
// while rx_ready is high.
//
// Modports:
//   master - the loader (drives rx_done, the RAM port and the BXU outputs)
//   slave  - the surrounding system (UART, BXU and RAM)
// ----------------------------------------------------------------------------
interface bxu_code_loader_if #(
    parameter int CODE_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 16
);
    logic [7:0]               rx_data;
    logic                     rx_ready;
    logic                     rx_done;

    logic [ADDR_BITWIDTH-1:0] bxu_code_addr;
    logic [CODE_BITWIDTH-1:0] bxu_code;
    logic                     bxu_rst_n;

    logic [ADDR_BITWIDTH-1:0] mem_addr;
    logic [CODE_BITWIDTH-1:0] mem_wdata;
    logic                     mem_we;
    logic [CODE_BITWIDTH-1:0] mem_rdata;

    modport master (
        input  rx_data, rx_ready, bxu_code_addr, mem_rdata,
        output rx_done, bxu_code, bxu_rst_n, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        output rx_data, rx_ready, bxu_code_addr, mem_rdata,
        input  rx_done, bxu_code, bxu_rst_n, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/bxu_code_loader.sv
// ----------------------------------------------------------------------------
// bxu_code_loader
//
// Program loader and code-memory arbiter for the BXU. A program arrives over
// the UART receive handshake as: length N (two bytes, little-endian) followed
// by N code words, each sent low byte first. Words are written to the shared
// code RAM from address 0 upward. While loading, the BXU is held in reset and
// the loader owns the RAM address; once loading completes the RAM address is
// handed to the BXU fetch address and the BXU is released.
//
// Optional feature macro: BXU_LOADER_CHECKSUM_EN
//   When defined, one extra byte follows the data and must equal the XOR of
//   all data bytes (0x00 for N=0); a mismatch ends in the error state.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   bus         - bxu_code_loader_if.master (UART rx, BXU fetch, code RAM)
//   reload      - one-cycle request to drop the current program and reload
//   busy        - high whenever the BXU is not running
//   err         - high in the error state (bad length or bad checksum)
//   word_cnt    - words written during the current load
//   dbg_state   - current FSM state, for debug/observation
// ----------------------------------------------------------------------------
module bxu_code_loader #(
    parameter int CODE_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 16,
    parameter int DEPTH         = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bxu_code_loader_if.master        bus,
    input  logic                     reload,
    output logic                     busy,
    output logic                     err,
    output logic [ADDR_BITWIDTH-1:0] word_cnt,
    output logic [2:0]               dbg_state
);

    // S_WRITE is the single cycle in which mem_we is high, between capturing
    // the high byte and moving on to the next word.
    localparam logic [2:0] S_LEN_LO  = 3'd0;
    localparam logic [2:0] S_LEN_HI  = 3'd1;
    localparam logic [2:0] S_DATA_LO = 3'd2;
    localparam logic [2:0] S_DATA_HI = 3'd3;
    localparam logic [2:0] S_CSUM    = 3'd4;
    localparam logic [2:0] S_RUN     = 3'd5;
    localparam logic [2:0] S_ERR     = 3'd6;
    localparam logic [2:0] S_WRITE   = 3'd7;

    logic [2:0]               state;
    logic [2:0]               state_nxt;
    logic                     armed;      // rx_ready seen low since last take
    logic [7:0]               len_lo;
    logic [7:0]               data_lo;
    logic [ADDR_BITWIDTH-1:0] len;
    logic [ADDR_BITWIDTH-1:0] ptr;
    logic [CODE_BITWIDTH-1:0] wdata;
    logic                     rx_done_q;
    logic                     bxu_rst_q;
    logic                     receiving;
    logic                     take;
    logic [15:0]              len_raw;
`ifdef BXU_LOADER_CHECKSUM_EN
    logic [7:0]               csum;
`endif

    assign receiving = (state == S_LEN_LO)  || (state == S_LEN_HI) ||
                       (state == S_DATA_LO) || (state == S_DATA_HI) ||
                       (state == S_CSUM);

    // reload wins over a byte offered in the same cycle; that byte is left
    // unacknowledged.
    assign take    = receiving && armed && bus.rx_ready && !reload;
    assign len_raw = {bus.rx_data, len_lo};

    always_comb begin
        state_nxt = state;
        if (reload) begin
            state_nxt = S_LEN_LO;
        end else begin
            case (state)
                S_LEN_LO:  if (take) state_nxt = S_LEN_HI;
                S_LEN_HI: begin
                    if (take) begin
                        if (int'(len_raw) > DEPTH) begin
                            state_nxt = S_ERR;
                        end else if (len_raw == 16'd0) begin
`ifdef BXU_LOADER_CHECKSUM_EN
                            state_nxt = S_CSUM;
`else
                            state_nxt = S_RUN;
`endif
                        end else begin
                            state_nxt = S_DATA_LO;
                        end
                    end
                end
                S_DATA_LO: if (take) state_nxt = S_DATA_HI;
                S_DATA_HI: if (take) state_nxt = S_WRITE;
                S_WRITE: begin
                    // word_cnt has not yet counted the word being written.
                    if (word_cnt + 1'b1 == len) begin
`ifdef BXU_LOADER_CHECKSUM_EN
                        state_nxt = S_CSUM;
`else
                        state_nxt = S_RUN;
`endif
                    end else begin
                        state_nxt = S_DATA_LO;
                    end
                end
`ifdef BXU_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (take) state_nxt = (bus.rx_data == csum) ? S_RUN : S_ERR;
                end
`endif
                default: state_nxt = state;  // RUN and ERR hold
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_LEN_LO;
            armed     <= 1'b1;
            len_lo    <= 8'd0;
            data_lo   <= 8'd0;
            len       <= '0;
            ptr       <= '0;
            word_cnt  <= '0;
            wdata     <= '0;
            rx_done_q <= 1'b0;
            bxu_rst_q <= 1'b0;
`ifdef BXU_LOADER_CHECKSUM_EN
            csum      <= 8'd0;
`endif
        end else begin
            state     <= state_nxt;
            rx_done_q <= take;
            // Registered from the next state so the release lines up with
            // the RAM address mux switching to the BXU.
            bxu_rst_q <= (state_nxt == S_RUN);

            if (take) begin
                armed <= 1'b0;
            end else if (!bus.rx_ready) begin
                armed <= 1'b1;
            end

            if (reload) begin
                ptr      <= '0;
                word_cnt <= '0;
                data_lo  <= 8'd0;
`ifdef BXU_LOADER_CHECKSUM_EN
                csum     <= 8'd0;
`endif
            end else begin
                if (take && state == S_LEN_LO) begin
                    len_lo <= bus.rx_data;
                end
                if (take && state == S_LEN_HI) begin
                    len <= ADDR_BITWIDTH'(len_raw);
                end
                if (take && state == S_DATA_LO) begin
                    data_lo <= bus.rx_data;
`ifdef BXU_LOADER_CHECKSUM_EN
                    csum    <= csum ^ bus.rx_data;
`endif
                end
                if (take && state == S_DATA_HI) begin
                    wdata <= {bus.rx_data, data_lo};
`ifdef BXU_LOADER_CHECKSUM_EN
                    csum  <= csum ^ bus.rx_data;
`endif
                end
                if (state == S_WRITE) begin
                    ptr      <= ptr + 1'b1;
                    word_cnt <= word_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.rx_done   = rx_done_q;
    assign bus.bxu_rst_n = bxu_rst_q;
    assign bus.mem_we    = (state == S_WRITE);
    assign bus.mem_wdata = wdata;
    assign bus.mem_addr  = (state == S_RUN) ? bus.bxu_code_addr : ptr;
    assign bus.bxu_code  = (state == S_RUN) ? bus.mem_rdata : '0;
    assign busy          = (state != S_RUN);
    assign err           = (state == S_ERR);
    assign dbg_state     = state;

endmodule

// File: tb/tb_bxu_code_loader.sv
`timescale 1ns/1ps
module tb_bxu_code_loader;
    localparam int CW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 256;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          reload = 1'b0;
    logic          busy;
    logic          err;
    logic [AW-1:0] word_cnt;
    logic [2:0]    dbg_state;

    bxu_code_loader_if #(.CODE_BITWIDTH(CW), .ADDR_BITWIDTH(AW)) bus();

    bxu_code_loader #(.CODE_BITWIDTH(CW), .ADDR_BITWIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.master),
        .reload    (reload),
        .busy      (busy),
        .err       (err),
        .word_cnt  (word_cnt),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset / code RAM ----------------
    always #5 clk = ~clk;

    logic [CW-1:0] ram [0:DEPTH-1];
    always @(posedge clk) if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
    assign bus.mem_rdata = ram[bus.mem_addr[7:0]];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [CW-1:0] data;
        logic [AW-1:0] cnt;
    } wr_t;

    wr_t  wr_q[$];
    int   cyc = 0;
    int   done_cnt = 0;
    int   last_we_cyc = -1;
    int   last_done_cyc = -1;
    int   rise_cyc = -1;
    logic prev_rst = 1'b0;
    int   viol = 0;

    always @(posedge clk) cyc++;

    // Passive monitor: logs writes and rx_done pulses, and watches the
    // ownership rules (BXU released only while the loader is idle in RUN).
    always @(negedge clk) begin
        if (bus.mem_we) begin
            wr_q.push_back(wr_t'{bus.mem_addr, bus.mem_wdata, word_cnt});
            last_we_cyc = cyc;
        end
        if (bus.rx_done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (bus.bxu_rst_n && !prev_rst) rise_cyc = cyc;
        prev_rst = bus.bxu_rst_n;
        if (bus.bxu_rst_n && busy) viol++;
        if (!busy && bus.mem_we) viol++;
        if (!busy && bus.mem_addr !== bus.bxu_code_addr) viol++;
        if (!busy && bus.bxu_code !== bus.mem_rdata) viol++;
        if (busy && bus.bxu_code !== '0) viol++;
    end

    // ---------------- driver tasks ----------------
    logic [7:0] data_q[$];

    // Offers one byte for at least 'hold' cycles, then drops rx_ready.
    task automatic send_byte(input logic [7:0] b, input int hold, input bit exp_ack);
        int acks;
        acks = 0;
        bus.rx_data  = b;
        bus.rx_ready = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.rx_done) acks++;
        end
        for (int i = 0; i < 40 && exp_ack && acks == 0; i++) begin
            @(negedge clk);
            if (bus.rx_done) acks++;
        end
        @(posedge clk); #1;
        bus.rx_ready = 1'b0;
        @(negedge clk);
        if (bus.rx_done) acks++;
        @(posedge clk); #1;
        check("rx_done_pulses_per_byte", acks, exp_ack ? 32'd1 : 32'd0);
    endtask

    task automatic pulse_reload();
        @(posedge clk); #1;
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        @(negedge clk);
        check("reload_busy", busy, 1'b1);
        check("reload_bxu_rst_n", bus.bxu_rst_n, 1'b0);
        check("reload_err", err, 1'b0);
        check("reload_word_cnt", word_cnt, '0);
        @(posedge clk); #1;
    endtask

    // Sends length + data_q (+ checksum) and checks the result against a
    // model derived from the byte stream.
    task automatic do_load(input logic [15:0] len, input int hold, input bit exp_err,
                           input int exp_words, input bit csum_bad);
        int         nsent;
        logic [7:0] x;
        logic [CW-1:0] w;
        int         k;
        wr_q.delete();
        done_cnt = 0;
        rise_cyc = -1;
        nsent    = 2;
        send_byte(len[7:0], hold, 1'b1);
        send_byte(len[15:8], hold, 1'b1);
        if (int'(len) <= DEPTH) begin
            x = 8'h00;
            foreach (data_q[i]) begin
                send_byte(data_q[i], hold, 1'b1);
                x = x ^ data_q[i];
                nsent++;
            end
`ifdef BXU_LOADER_CHECKSUM_EN
            if (csum_bad) x = x ^ 8'h01;
            send_byte(x, hold, 1'b1);
            nsent++;
`else
            if (csum_bad) $display("note: checksum corruption ignored without checksum support");
`endif
        end
        repeat (3) @(negedge clk);
        check("load_err", err, exp_err);
        check("load_bxu_rst_n", bus.bxu_rst_n, !exp_err);
        check("load_busy", busy, exp_err);
        check("load_word_cnt", word_cnt, AW'(exp_words));
        check("load_rx_done_total", done_cnt, nsent);
        check("load_write_count", wr_q.size(), exp_words);
        for (int i = 0; i < wr_q.size() && i < exp_words; i++) begin
            w = {data_q[2*i+1], data_q[2*i]};
            check("write_addr", wr_q[i].addr, i);
            check("write_data", wr_q[i].data, w);
            check("write_word_cnt_before", wr_q[i].cnt, i);
        end
        if (!exp_err) begin
`ifdef BXU_LOADER_CHECKSUM_EN
            check("rst_rise_after_last_byte", rise_cyc, last_done_cyc);
`else
            if (len == 16'd0) check("rst_rise_after_len", rise_cyc, last_done_cyc);
            else              check("rst_rise_after_write", rise_cyc, last_we_cyc + 1);
`endif
            for (int r = 0; r < 3 && len != 16'd0; r++) begin
                k = (r == 0) ? 0 : (r == 1) ? int'(len) - 1 : $urandom_range(0, int'(len) - 1);
                @(posedge clk); #1;
                bus.bxu_code_addr = AW'(k);
                @(negedge clk);
                check("bxu_code_fetch", bus.bxu_code, {data_q[2*k+1], data_q[2*k]});
            end
        end else begin
            @(posedge clk); #1;
            send_byte(8'h5a, 3, 1'b0);
            check("err_holds", err, 1'b1);
            check("err_bxu_rst_n", bus.bxu_rst_n, 1'b0);
        end
        @(posedge clk); #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] len;
        int          hold;
        bit          fixed;
        bit          exp_err;
        int          exp_words;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{16'd2,     1,  1'b1, 1'b0, 2};
        vecs[1] = '{16'd0,     1,  1'b0, 1'b0, 0};
        vecs[2] = '{16'd1,     10, 1'b0, 1'b0, 1};
        vecs[3] = '{16'd5,     3,  1'b0, 1'b0, 5};
        vecs[4] = '{16'd256,   1,  1'b0, 1'b0, 256};
        vecs[5] = '{16'h0101,  1,  1'b0, 1'b1, 0};
        vecs[6] = '{16'hffff,  2,  1'b0, 1'b1, 0};

        bus.rx_data       = 8'h00;
        bus.rx_ready      = 1'b0;
        bus.bxu_code_addr = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_done", bus.rx_done, 1'b0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_bxu_rst_n", bus.bxu_rst_n, 1'b0);
        check("rst_busy", busy, 1'b1);
        check("rst_err", err, 1'b0);
        check("rst_word_cnt", word_cnt, '0);
        check("rst_mem_wdata", bus.mem_wdata, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven loads, randomized payloads
        for (int v = 0; v < 7; v++) begin
            if (v != 0) pulse_reload();
            data_q.delete();
            if (vecs[v].fixed) begin
                data_q.push_back(8'h34); data_q.push_back(8'h12);
                data_q.push_back(8'h78); data_q.push_back(8'h56);
            end else if (int'(vecs[v].len) <= DEPTH) begin
                for (int i = 0; i < 2 * int'(vecs[v].len); i++)
                    data_q.push_back(8'($urandom_range(0, 255)));
            end
            do_load(vecs[v].len, vecs[v].hold, vecs[v].exp_err, vecs[v].exp_words, 1'b0);
        end

        // Reload during DATA_HI, coincident with a byte offer
        pulse_reload();
        send_byte(8'h02, 1, 1'b1);
        send_byte(8'h00, 1, 1'b1);
        send_byte(8'h11, 1, 1'b1);
        wr_q.delete();
        done_cnt = 0;
        bus.rx_data  = 8'h22;
        bus.rx_ready = 1'b1;
        reload       = 1'b1;
        @(posedge clk); #1;
        reload       = 1'b0;
        bus.rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reload_hi_no_rx_done", done_cnt, 0);
        check("reload_hi_no_write", wr_q.size(), 0);
        check("reload_hi_word_cnt", word_cnt, '0);
        check("reload_hi_busy", busy, 1'b1);
        check("reload_hi_bxu_rst_n", bus.bxu_rst_n, 1'b0);
        @(posedge clk); #1;
        data_q.delete();
        for (int i = 0; i < 4; i++) data_q.push_back(8'($urandom_range(0, 255)));
        do_load(16'd2, 2, 1'b0, 2, 1'b0);

        // Asynchronous reset in the middle of a load
        pulse_reload();
        send_byte(8'h03, 1, 1'b1);
        send_byte(8'h00, 1, 1'b1);
        send_byte(8'haa, 1, 1'b1);
        send_byte(8'hbb, 1, 1'b1);
        send_byte(8'hcc, 1, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_rx_done", bus.rx_done, 1'b0);
        check("arst_mem_we", bus.mem_we, 1'b0);
        check("arst_bxu_rst_n", bus.bxu_rst_n, 1'b0);
        check("arst_busy", busy, 1'b1);
        check("arst_err", err, 1'b0);
        check("arst_word_cnt", word_cnt, '0);
        check("arst_mem_wdata", bus.mem_wdata, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        data_q.delete();
        for (int i = 0; i < 6; i++) data_q.push_back(8'($urandom_range(0, 255)));
        do_load(16'd3, 1, 1'b0, 3, 1'b0);

`ifdef BXU_LOADER_CHECKSUM_EN
        // 01 00 AA 55 FF -> RUN, then 01 00 AA 55 FE -> ERR
        pulse_reload();
        data_q.delete();
        data_q.push_back(8'haa); data_q.push_back(8'h55);
        do_load(16'd1, 1, 1'b0, 1, 1'b0);
        pulse_reload();
        do_load(16'd1, 1, 1'b1, 1, 1'b1);
`endif

        check("ownership_violations", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
